// File: rtl/hilo_mul_unit.sv
// Hi/Lo owner for the EX stage: iterative shift-add multiplier with
// multiply, accumulate, subtract-accumulate and direct Hi/Lo writes.
module hilo_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MUL    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sign_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] final_p;
  logic [2*WIDTH-1:0] new_hilo;

  always_comb begin
    is_signed = (Op != OP_MULTU);
    abs_a     = (is_signed && A[WIDTH-1]) ? -A : A;
    abs_b     = (is_signed && B[WIDTH-1]) ? -B : B;
    // Carry out of the upper-half add becomes the new MSB after the shift.
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    final_p   = sign_q ? -prod : prod;
    case (op_q)
      OP_MADD: new_hilo = {Hi, Lo} + final_p;
      OP_MSUB: new_hilo = {Hi, Lo} - final_p;
      default: new_hilo = final_p;
    endcase
  end

  assign Busy = (state != S_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      mcand  <= '0;
      mplier <= '0;
      sign_q <= 1'b0;
      prod   <= '0;
      count  <= '0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (!Op[2]) begin
              op_q   <= Op;
              mcand  <= abs_a;
              mplier <= abs_b;
              sign_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              prod   <= '0;
              count  <= '0;
              state  <= S_MUL;
            end else if (Op == OP_MTHI) begin
              Hi   <= A;
              Done <= 1'b1;
            end else if (Op == OP_MTLO) begin
              Lo   <= A;
              Done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod   <= {step_sum, prod[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= S_FINISH;
        end
        S_FINISH: begin
          {Hi, Lo} <= new_hilo;
          Done     <= 1'b1;
          count    <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
